// File: rtl/alarm_ring_ctrl_if.sv
// Signal bundle between the alarm clock core and the ring controller:
// second tick, comparator flags and keys in, buzzer/status out.
interface alarm_ring_ctrl_if;
    logic       tick_1hz;
    logic [2:0] alarm_req;
    logic       key_stop;
    logic       key_snooze;
    logic       buzzer_en;
    logic       ringing;
    logic [1:0] active_id;
    logic [2:0] snooze_busy;

    modport master (
        output tick_1hz, alarm_req, key_stop, key_snooze,
        input  buzzer_en, ringing, active_id, snooze_busy
    );

    modport slave (
        input  tick_1hz, alarm_req, key_stop, key_snooze,
        output buzzer_en, ringing, active_id, snooze_busy
    );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Arbitrates three alarm sources onto one buzzer: edge-triggered pending
// requests, fixed-priority service, timed auto-stop and per-alarm snooze.
module alarm_ring_ctrl #(
    parameter int RING_SEC   = 10,
    parameter int SNOOZE_SEC = 60,
    parameter int SNOOZE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    alarm_ring_ctrl_if.slave   bus
);
    localparam logic [5:0] RING_INIT   = 6'(RING_SEC);
    localparam logic [6:0] SNOOZE_INIT = 7'(SNOOZE_SEC);
    localparam logic [1:0] USE_MAX     = 2'(SNOOZE_MAX);

    typedef enum logic {IDLE, RING} state_t;

    state_t     state_reg, state_next;
    logic [5:0] ring_cnt_reg, ring_cnt_next;
    logic       beep_reg, beep_next;
    logic [1:0] active_reg, active_next;
    logic [2:0] req_reg;
    logic       armed_reg;

    logic [2:0] pend;
    logic [2:0] req_rise;
    logic [2:0] snz_busy;
    logic [2:0] use_at_max;
    logic [2:0] pend_clr;
    logic [2:0] snz_load;
    logic [2:0] use_clr;
    logic [2:0] use_inc;
    logic [1:0] grant;
    logic [2:0] ring_mask;

    // armed_reg masks the first cycle after reset so a level already high is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_reg   <= 3'b000;
            armed_reg <= 1'b0;
        end else begin
            req_reg   <= bus.alarm_req;
            armed_reg <= 1'b1;
        end
    end

    assign ring_mask = (state_reg == RING) ? (3'b001 << active_reg) : 3'b000;
    assign req_rise  = armed_reg ? (bus.alarm_req & ~req_reg & ~ring_mask) : 3'b000;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_alarm
            logic [6:0] snz_cnt_reg;
            logic [1:0] use_cnt_reg;
            logic       pend_bit_reg;
            logic       snz_expire;

            assign snz_expire     = bus.tick_1hz && (snz_cnt_reg == 7'd1);
            assign snz_busy[gi]   = (snz_cnt_reg != 7'd0);
            assign use_at_max[gi] = (use_cnt_reg == USE_MAX);
            assign pend[gi]       = pend_bit_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    snz_cnt_reg  <= 7'd0;
                    use_cnt_reg  <= 2'd0;
                    pend_bit_reg <= 1'b0;
                end else begin
                    // A fresh edge during snooze replaces the countdown with an immediate ring
                    if (snz_load[gi])
                        snz_cnt_reg <= SNOOZE_INIT;
                    else if (req_rise[gi])
                        snz_cnt_reg <= 7'd0;
                    else if (bus.tick_1hz && snz_busy[gi])
                        snz_cnt_reg <= snz_cnt_reg - 7'd1;

                    if (use_clr[gi])
                        use_cnt_reg <= 2'd0;
                    else if (use_inc[gi])
                        use_cnt_reg <= use_cnt_reg + 2'd1;

                    pend_bit_reg <= (pend_bit_reg | req_rise[gi] | snz_expire) & ~pend_clr[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ring_cnt_reg <= 6'd0;
            beep_reg     <= 1'b0;
            active_reg   <= 2'd0;
        end else begin
            state_reg    <= state_next;
            ring_cnt_reg <= ring_cnt_next;
            beep_reg     <= beep_next;
            active_reg   <= active_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ring_cnt_next = ring_cnt_reg;
        beep_next     = beep_reg;
        active_next   = active_reg;
        pend_clr      = 3'b000;
        snz_load      = 3'b000;
        use_clr       = 3'b000;
        use_inc       = 3'b000;

        grant = 2'd2;
        if (pend[1]) grant = 2'd1;
        if (pend[0]) grant = 2'd0;

        case (state_reg)
            IDLE: begin
                if (|pend) begin
                    state_next      = RING;
                    active_next     = grant;
                    pend_clr[grant] = 1'b1;
                    ring_cnt_next   = RING_INIT;
                    beep_next       = 1'b1;
                end
            end
            RING: begin
                // Keys outrank the timeout tick; stop outranks snooze
                if (bus.key_stop || (bus.key_snooze && use_at_max[active_reg])) begin
                    state_next          = IDLE;
                    use_clr[active_reg] = 1'b1;
                end else if (bus.key_snooze) begin
                    state_next           = IDLE;
                    snz_load[active_reg] = 1'b1;
                    use_inc[active_reg]  = 1'b1;
                end else if (bus.tick_1hz) begin
                    if (ring_cnt_reg == 6'd1) begin
                        state_next          = IDLE;
                        use_clr[active_reg] = 1'b1;
                    end else begin
                        ring_cnt_next = ring_cnt_reg - 6'd1;
                        beep_next     = ~beep_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.ringing     = (state_reg == RING);
    assign bus.buzzer_en   = (state_reg == RING) && beep_reg;
    assign bus.active_id   = active_reg;
    assign bus.snooze_busy = snz_busy;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for the alarm ring controller with a seconds-level reference
// model checked every cycle plus hand-computed expectations.
module tb_alarm_ring_ctrl;
    localparam int RING_SEC   = 10;
    localparam int SNOOZE_SEC = 60;
    localparam int SNOOZE_MAX = 3;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 0;

    alarm_ring_ctrl_if ab();

    alarm_ring_ctrl #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .SNOOZE_MAX(SNOOZE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ab)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: which alarm rings, seconds elapsed in this ring,
    // pending requests, seconds of snooze left and snoozes used per alarm.
    bit m_ring;
    int m_id;
    int m_elapsed;
    bit m_armed;
    bit m_pend [3];
    int m_snz  [3];
    int m_uses [3];
    bit m_prev [3];
    bit m_rise [3];
    bit m_exp;
    int m_load;
    int m_grant;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ring = 0; m_id = 0; m_elapsed = 0; m_armed = 0;
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 0; m_snz[i] = 0; m_uses[i] = 0; m_prev[i] = 0;
            end
        end else begin
            m_load = -1;
            m_grant = -1;
            for (int i = 0; i < 3; i++)
                m_rise[i] = m_armed && ab.alarm_req[i] && !m_prev[i] && !(m_ring && m_id == i);
            if (!m_ring) begin
                for (int i = 2; i >= 0; i--)
                    if (m_pend[i]) m_grant = i;
                if (m_grant >= 0) begin
                    m_ring = 1; m_id = m_grant; m_elapsed = 0;
                end
            end else if (ab.key_stop || (ab.key_snooze && m_uses[m_id] == SNOOZE_MAX)) begin
                m_ring = 0; m_uses[m_id] = 0;
            end else if (ab.key_snooze) begin
                m_ring = 0; m_load = m_id; m_uses[m_id] = m_uses[m_id] + 1;
            end else if (ab.tick_1hz) begin
                if (m_elapsed + 1 == RING_SEC) begin
                    m_ring = 0; m_uses[m_id] = 0;
                end else begin
                    m_elapsed = m_elapsed + 1;
                end
            end
            for (int i = 0; i < 3; i++) begin
                m_exp = ab.tick_1hz && (m_snz[i] == 1);
                if (m_rise[i] || m_exp) m_pend[i] = 1;
                if (i == m_grant) m_pend[i] = 0;
                if (i == m_load) m_snz[i] = SNOOZE_SEC;
                else if (m_rise[i]) m_snz[i] = 0;
                else if (ab.tick_1hz && m_snz[i] > 0) m_snz[i] = m_snz[i] - 1;
                m_prev[i] = ab.alarm_req[i];
            end
            m_armed = 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model ringing", int'(ab.ringing), int'(m_ring));
            chk("model buzzer_en", int'(ab.buzzer_en), int'(m_ring && (m_elapsed % 2 == 0)));
            chk("model active_id", int'(ab.active_id), m_id);
            chk("model snooze_busy", int'(ab.snooze_busy),
                int'({m_snz[2] > 0, m_snz[1] > 0, m_snz[0] > 0}));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input logic [2:0] v);
        ab.alarm_req = v;
        $display("tx: alarm_req=%b", v);
    endtask

    task automatic pulse(input bit stop, input bit snz, input bit tick);
        ab.key_stop   = stop;
        ab.key_snooze = snz;
        ab.tick_1hz   = tick;
        @(negedge clk);
        ab.key_stop   = 1'b0;
        ab.key_snooze = 1'b0;
        ab.tick_1hz   = 1'b0;
        if (stop || snz)
            $display("tx: key stop=%0d snooze=%0d tick=%0d -> ringing=%0d busy=%b",
                     stop, snz, tick, ab.ringing, ab.snooze_busy);
    endtask

    task automatic tick_gap();
        pulse(0, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ab.tick_1hz = 0; ab.alarm_req = 3'b000; ab.key_stop = 0; ab.key_snooze = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cyc(3);
        chk("reset ringing", int'(ab.ringing), 0);
        chk("reset buzzer", int'(ab.buzzer_en), 0);
        chk("reset active_id", int'(ab.active_id), 0);
        chk("reset snooze_busy", int'(ab.snooze_busy), 0);
        rst_n = 1'b1;
        cmp_en = 1;
        cyc(3);

        // Single alarm, no keys: auto-stop on the tenth tick
        set_req(3'b001);
        cyc(1);
        chk("rise+1 ringing", int'(ab.ringing), 0);
        cyc(1);
        chk("rise+2 ringing", int'(ab.ringing), 1);
        chk("rise+2 active_id", int'(ab.active_id), 0);
        chk("rise+2 buzzer", int'(ab.buzzer_en), 1);
        for (int k = 1; k <= 10; k++) begin
            pulse(0, 0, 1);
            if (k < 10) begin
                chk("tick ringing", int'(ab.ringing), 1);
                chk("tick buzzer", int'(ab.buzzer_en), (k % 2 == 0) ? 1 : 0);
            end else begin
                chk("timeout ringing", int'(ab.ringing), 0);
            end
            @(negedge clk);
        end
        set_req(3'b000);
        cyc(2);

        // Priority ordering of requests arriving during a ring
        set_req(3'b100);
        cyc(2);
        chk("alarm3 active_id", int'(ab.active_id), 2);
        set_req(3'b111);
        cyc(2);
        pulse(1, 0, 0);
        chk("stop3 ringing", int'(ab.ringing), 0);
        @(negedge clk);
        chk("next ring id", int'(ab.active_id), 0);
        chk("next ring on", int'(ab.ringing), 1);
        pulse(1, 0, 0);
        @(negedge clk);
        chk("third ring id", int'(ab.active_id), 1);
        pulse(1, 0, 0);
        set_req(3'b000);
        cyc(3);
        chk("queue drained", int'(ab.ringing), 0);

        // Snooze three times, the fourth acts as stop
        set_req(3'b010);
        cyc(2);
        chk("alarm2 ringing", int'(ab.ringing), 1);
        for (int r = 1; r <= 3; r++) begin
            pulse(0, 1, 0);
            chk("snooze ringing", int'(ab.ringing), 0);
            chk("snooze busy", int'(ab.snooze_busy), 3'b010);
            for (int t = 1; t < SNOOZE_SEC; t++) tick_gap();
            chk("tick59 busy", int'(ab.snooze_busy), 3'b010);
            pulse(0, 0, 1);
            chk("tick60 busy", int'(ab.snooze_busy), 0);
            @(negedge clk);
            chk("resnooze ringing", int'(ab.ringing), 1);
            chk("resnooze id", int'(ab.active_id), 1);
        end
        pulse(0, 1, 0);
        chk("4th snooze ringing", int'(ab.ringing), 0);
        chk("4th snooze busy", int'(ab.snooze_busy), 0);
        cyc(3);
        chk("4th snooze stays idle", int'(ab.ringing), 0);
        set_req(3'b000);
        cyc(2);

        // Keys in IDLE ignored; stop+snooze together is a stop
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        chk("idle keys busy", int'(ab.snooze_busy), 0);
        set_req(3'b001);
        cyc(2);
        pulse(1, 1, 0);
        chk("both ringing", int'(ab.ringing), 0);
        chk("both busy", int'(ab.snooze_busy), 0);
        set_req(3'b000);
        cyc(1);

        // Snooze coinciding with the timeout tick wins, then re-rise cancels snooze
        set_req(3'b001);
        cyc(2);
        for (int k = 1; k <= 9; k++) tick_gap();
        pulse(0, 1, 1);
        chk("snooze@timeout busy", int'(ab.snooze_busy), 3'b001);
        set_req(3'b000);
        cyc(1);
        set_req(3'b001);
        cyc(1);
        chk("rerise busy cleared", int'(ab.snooze_busy), 0);
        @(negedge clk);
        chk("rerise ringing", int'(ab.ringing), 1);
        pulse(1, 0, 0);
        set_req(3'b000);
        cyc(2);

        // Reset mid-ring with a pending request and levels still high
        set_req(3'b010);
        cyc(2);
        set_req(3'b110);
        cyc(1);
        chk("pre-reset ringing", int'(ab.ringing), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset ringing", int'(ab.ringing), 0);
        chk("async reset buzzer", int'(ab.buzzer_en), 0);
        chk("async reset id", int'(ab.active_id), 0);
        chk("async reset busy", int'(ab.snooze_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5);
        chk("no replay after reset", int'(ab.ringing), 0);
        set_req(3'b000);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
